// File: rtl/color_pixel_pipe.sv
// color_pixel_pipe: two-stage valid/ready pipeline that splits a packed
// {green, blue, red} colour code into DAC channels, widening each field by
// bit replication, then applying dimming (>>1) and blanking.
// Optional feature macro: COLOR_PIXEL_PALETTE_EN adds a writable
// 2^CODE_W-entry palette that can replace field expansion per pixel.
module color_pixel_pipe #(
  parameter int unsigned CH_BITS  = 2,
  parameter int unsigned OUT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3*CH_BITS-1:0]    in_code,
  input  logic                    in_blank,
  input  logic                    dim,
`ifdef COLOR_PIXEL_PALETTE_EN
  input  logic                    pal_sel,
  input  logic                    pal_we,
  input  logic [3*CH_BITS-1:0]    pal_addr,
  input  logic [3*OUT_BITS-1:0]   pal_wdata,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_BITS-1:0]     out_red,
  output logic [OUT_BITS-1:0]     out_green,
  output logic [OUT_BITS-1:0]     out_blue
);

  localparam int unsigned CODE_W = 3 * CH_BITS;

  if (OUT_BITS < CH_BITS) begin : g_bad_width
    $error("color_pixel_pipe: OUT_BITS must be >= CH_BITS");
  end

  // Widen one field: output bit i copies input bit
  // CH_BITS-1 - ((OUT_BITS-1-i) mod CH_BITS), i.e. the field repeated MSB-first.
  function automatic logic [OUT_BITS-1:0] expand(input logic [CH_BITS-1:0] ch);
    logic [OUT_BITS-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < OUT_BITS; i++) begin
      r[i] = ch[CH_BITS-1 - ((OUT_BITS-1-i) % CH_BITS)];
    end
    return r;
  endfunction

  logic                s1_valid, s2_valid;
  logic [CH_BITS-1:0]  s1_red, s1_blue, s1_green;
  logic                s1_blank, s1_dim;
  logic                adv2, accept;
  logic [OUT_BITS-1:0] x_red, x_green, x_blue;
  logic [OUT_BITS-1:0] n_red, n_green, n_blue;

  assign adv2      = s1_valid && (!s2_valid || out_ready);
  assign in_ready  = !s1_valid || adv2;
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid;

`ifdef COLOR_PIXEL_PALETTE_EN
  logic [3*OUT_BITS-1:0] pal_mem [2**CODE_W];
  logic                  s1_pal;
  logic [3*OUT_BITS-1:0] s1_pal_data;

  // Palette storage: synchronous write, deliberately not reset.
  always_ff @(posedge clk) begin
    if (pal_we) pal_mem[pal_addr] <= pal_wdata;
  end

  // Palette lookup is captured at stage 1 so it reads pre-write data on a
  // same-cycle write to the same entry; stage 2 then picks it over expansion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_pal      <= 1'b0;
      s1_pal_data <= '0;
    end else if (accept) begin
      s1_pal      <= pal_sel;
      s1_pal_data <= pal_mem[in_code];
    end
  end
`endif

  // Stage 1: capture the code fields and sideband on an input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_red   <= '0;
      s1_blue  <= '0;
      s1_green <= '0;
      s1_blank <= 1'b0;
      s1_dim   <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_red   <= in_code[CH_BITS-1:0];
      s1_blue  <= in_code[2*CH_BITS-1:CH_BITS];
      s1_green <= in_code[CODE_W-1:2*CH_BITS];
      s1_blank <= in_blank;
      s1_dim   <= dim;
    end else if (adv2) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage-2 next values: expand (or palette), then dim, then blank.
  always_comb begin
    x_red   = expand(s1_red);
    x_green = expand(s1_green);
    x_blue  = expand(s1_blue);
`ifdef COLOR_PIXEL_PALETTE_EN
    if (s1_pal) begin
      x_red   = s1_pal_data[OUT_BITS-1:0];
      x_blue  = s1_pal_data[2*OUT_BITS-1:OUT_BITS];
      x_green = s1_pal_data[3*OUT_BITS-1:2*OUT_BITS];
    end
`endif
    n_red   = s1_dim ? (x_red   >> 1) : x_red;
    n_green = s1_dim ? (x_green >> 1) : x_green;
    n_blue  = s1_dim ? (x_blue  >> 1) : x_blue;
    if (s1_blank) begin
      n_red   = '0;
      n_green = '0;
      n_blue  = '0;
    end
  end

  // Stage 2: output registers; hold while the downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      out_red   <= '0;
      out_green <= '0;
      out_blue  <= '0;
    end else if (adv2) begin
      s2_valid  <= 1'b1;
      out_red   <= n_red;
      out_green <= n_green;
      out_blue  <= n_blue;
    end else if (out_ready) begin
      s2_valid  <= 1'b0;
    end
  end

endmodule
